// File: rtl/meter_request_arbiter_pkg.sv
// Shared types and constants for the parking-meter request front end.
// Command opcodes, request indices, default amounts and the round-robin helper.
package meter_request_arbiter_pkg;

  typedef enum logic {
    OP_ADD  = 1'b0,
    OP_LOAD = 1'b1
  } cmd_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_OFFER
  } arb_state_e;

  localparam int NUM_REQ  = 6;
  localparam int IDX_ADD1 = 0;
  localparam int IDX_ADD2 = 1;
  localparam int IDX_ADD3 = 2;
  localparam int IDX_ADD4 = 3;
  localparam int IDX_RST1 = 4;
  localparam int IDX_RST2 = 5;

  localparam logic [13:0] AMT_ADD1_DEF = 14'd60;
  localparam logic [13:0] AMT_ADD2_DEF = 14'd120;
  localparam logic [13:0] AMT_ADD3_DEF = 14'd180;
  localparam logic [13:0] AMT_ADD4_DEF = 14'd300;
  localparam logic [13:0] LOAD1_DEF    = 14'd16;
  localparam logic [13:0] LOAD2_DEF    = 14'd150;

  localparam int MAX_SECONDS = 9999;

  // First requesting add button found when scanning upward from ptr, wrapping at 4.
  function automatic logic [1:0] rrPick(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    rrPick = ptr;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) rrPick = idx;
    end
  endfunction

endpackage

// File: rtl/meter_request_arbiter_btn_debounce.sv
// Single-button conditioner: 2-FF synchroniser, stability counter and a
// one-cycle press pulse on each accepted rising level. Releases produce no pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  // Counter only runs while the synchronised level disagrees with the accepted one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      press_q <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DEB_LAST) begin
        stable_q <= sync2_q;
        press_q  <= sync2_q;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/meter_request_arbiter.sv
// Parking-meter front end: debounces six buttons, queues one request per button,
// arbitrates them onto a valid/ready command port and generates the 1 Hz tick and blink phase.
module meter_request_arbiter
  import meter_request_arbiter_pkg::*;
#(
  parameter int          DEB_CYCLES  = 1_000_000,
  parameter int          TICK_CYCLES = 100_000_000,
  parameter logic [13:0] AMT0        = AMT_ADD1_DEF,
  parameter logic [13:0] AMT1        = AMT_ADD2_DEF,
  parameter logic [13:0] AMT2        = AMT_ADD3_DEF,
  parameter logic [13:0] AMT3        = AMT_ADD4_DEF,
  parameter logic [13:0] LOAD1       = LOAD1_DEF,
  parameter logic [13:0] LOAD2       = LOAD2_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  add_btn,
  input  logic        rst1_btn,
  input  logic        rst2_btn,
  input  logic        cmd_ready,
  output logic        cmd_valid,
  output logic        cmd_op,
  output logic [13:0] cmd_amount,
  output logic        tick_1hz,
  output logic        blink_on,
  output logic        busy,
  output logic        drop
);

  localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(TICK_CYCLES / 2);

  logic [NUM_REQ-1:0] rawBtn;
  logic [NUM_REQ-1:0] pressEv;

  assign rawBtn = {rst2_btn, rst1_btn, add_btn};

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (rawBtn[g]),
      .press_o(pressEv[g])
    );
  end

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [1:0]         rrPtr_q;
  logic [2:0]         grantIdx_q;
  cmd_op_e            op_q;
  logic [13:0]        amount_q;
  logic               valid_q;
  logic               busy_q;
  logic               drop_q;
  logic [TICK_W-1:0]  tickCnt_q, tickCnt_d;
  logic               tick_q;
  logic               blink_q;

  logic               accept;
  logic [NUM_REQ-1:0] clrMask;
  logic               dropNow;
  logic [1:0]         addPick;
  logic [2:0]         winIdx;
  cmd_op_e            winOp;
  logic [13:0]        winAmt;

  // A press landing on the same cycle its bit is cleared re-arms the bit instead of dropping.
  always_comb begin
    accept    = (state_q == ST_OFFER) && cmd_ready;
    clrMask   = accept ? (NUM_REQ'(1) << grantIdx_q) : '0;
    pend_d    = (pend_q & ~clrMask) | pressEv;
    dropNow   = |(pressEv & pend_q & ~clrMask);
    tickCnt_d = tickCnt_q + TICK_W'(1);
    if (accept && (op_q == OP_LOAD)) begin
      tickCnt_d = '0;
    end else if (tickCnt_q == TICK_LAST) begin
      tickCnt_d = '0;
    end
  end

  always_comb begin
    addPick = rrPick(pend_q[IDX_ADD4:IDX_ADD1], rrPtr_q);
    winIdx  = {1'b0, addPick};
    winOp   = OP_ADD;
    winAmt  = AMT0;
    if (pend_q[IDX_RST1]) begin
      winIdx = 3'(IDX_RST1);
      winOp  = OP_LOAD;
      winAmt = LOAD1;
    end else if (pend_q[IDX_RST2]) begin
      winIdx = 3'(IDX_RST2);
      winOp  = OP_LOAD;
      winAmt = LOAD2;
    end else begin
      case (addPick)
        2'd0:    winAmt = AMT0;
        2'd1:    winAmt = AMT1;
        2'd2:    winAmt = AMT2;
        default: winAmt = AMT3;
      endcase
    end
  end

  // Offer is latched in IDLE and held unchanged until the meter takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      rrPtr_q    <= '0;
      grantIdx_q <= '0;
      op_q       <= OP_ADD;
      amount_q   <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      tickCnt_q  <= '0;
      tick_q     <= 1'b0;
      blink_q    <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      drop_q    <= dropNow;
      tickCnt_q <= tickCnt_d;
      tick_q    <= (tickCnt_d == TICK_LAST);
      blink_q   <= (tickCnt_d < TICK_HALF);
      case (state_q)
        ST_IDLE: begin
          if (|pend_q) begin
            grantIdx_q <= winIdx;
            op_q       <= winOp;
            amount_q   <= winAmt;
            valid_q    <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (cmd_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
            if (op_q == OP_ADD) rrPtr_q <= grantIdx_q[1:0] + 2'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cmd_valid  = valid_q;
  assign cmd_op     = op_q;
  assign cmd_amount = amount_q;
  assign busy       = busy_q;
  assign drop       = drop_q;
  assign tick_1hz   = tick_q;
  assign blink_on   = blink_q;

endmodule
